// File: rtl/vector_processor_defs.sv
// -----------------------------------------------------------------------------
// vector_processor_defs
// Shared types for the vector processor front end: instruction field
// encodings, the sequencer FSM state type and the registered decode bundle
// passed from vec_inst_decode to vec_seq_controller.
// -----------------------------------------------------------------------------
package vector_processor_defs;

    // Major opcodes (vec_inst[6:0]).
    typedef enum logic [6:0] {
        V_LOAD  = 7'b0000111,
        V_ARITH = 7'b1010111
    } v_opcode_e;

    // func3 field (vec_inst[14:12]) of V_ARITH; CONF selects vset{i}vl{i}.
    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        CONF  = 3'b111
    } v_func3_e;

    // Load addressing mode (vec_inst[27:26]).
    typedef enum logic [1:0] {
        MOP_UNIT    = 2'b00,
        MOP_IDX_UNO = 2'b01,
        MOP_STRIDE  = 2'b10,
        MOP_IDX_ORD = 2'b11
    } v_mop_e;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONFIG   = 3'd1,
        EXEC     = 3'd2,
        MEM_WAIT = 3'd3,
        DONE     = 3'd4
    } vseq_state_e;

    // Operand mux 1 selection used by loads (memory data path).
    localparam logic [1:0] MUX1_MEM = 2'b01;

    // Decode outputs, registered as a group on instruction acceptance.
    typedef struct packed {
        logic       vl_sel;
        logic       vtype_sel;
        logic       rs1_sel;
        logic       rs1rd_de;
        logic       lumop_sel;
        logic       mask_operation;
        logic       mask_wr_en;
        logic [1:0] data_mux1_sel;
        logic       data_mux2_sel;
        logic       stride_sel;
        logic       ld_inst;
    } vdec_t;

endpackage

// File: rtl/vec_inst_decode.sv
// -----------------------------------------------------------------------------
// vec_inst_decode
// Purely combinational decode of a vector instruction word.
//   inst_i    : instruction word from the scalar core
//   dec_o     : decode bundle (registered by the sequencer on acceptance)
//   is_conf_o : vsetvli / vsetivli / vsetvl
//   is_vec_o  : beat-sequenced instruction (arithmetic or load)
//   is_load_o : vector load
// Config selects: vsetivli takes vl and vtype from immediates (vl_sel =
// vtype_sel = 1); vsetvli takes vtype from the immediate (vtype_sel = 1);
// vsetvl takes vtype from rs2 (vtype_sel = 0).
// -----------------------------------------------------------------------------
module vec_inst_decode
    import vector_processor_defs::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] inst_i,
    output vdec_t           dec_o,
    output logic            is_conf_o,
    output logic            is_vec_o,
    output logic            is_load_o
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] mop;
    logic       rs1_rd_zero;
    logic       unused_inst_bits;

    assign opcode      = inst_i[6:0];
    assign func3       = inst_i[14:12];
    assign mop         = inst_i[27:26];
    assign rs1_rd_zero = (inst_i[19:15] == 5'd0) && (inst_i[11:7] == 5'd0);

    // Remaining instruction bits carry operands handled downstream.
    assign unused_inst_bits = ^inst_i;

    always_comb begin
        dec_o     = '0;
        is_conf_o = 1'b0;
        is_vec_o  = 1'b0;
        is_load_o = 1'b0;

        if (opcode == V_ARITH) begin
            if (func3 == CONF) begin
                is_conf_o = 1'b1;
                if (inst_i[31:30] == 2'b11) begin
                    // vsetivli
                    dec_o.vl_sel    = 1'b1;
                    dec_o.vtype_sel = 1'b1;
                    dec_o.rs1rd_de  = 1'b1;
                    dec_o.rs1_sel   = 1'b0;
                end else begin
                    // vsetvli (bit 31 clear) or vsetvl (bits 31:30 = 10)
                    dec_o.vtype_sel = ~inst_i[31];
                    dec_o.rs1_sel   = rs1_rd_zero;
                    dec_o.rs1rd_de  = ~rs1_rd_zero;
                end
            end else begin
                is_vec_o = 1'b1;
            end
        end else if (opcode == V_LOAD) begin
            is_vec_o            = 1'b1;
            is_load_o           = 1'b1;
            dec_o.ld_inst       = 1'b1;
            dec_o.data_mux1_sel = MUX1_MEM;
            case (mop)
                MOP_UNIT: begin
                    dec_o.stride_sel    = 1'b1;
                    dec_o.lumop_sel     = 1'b1;
                    dec_o.data_mux2_sel = 1'b1;
                end
                MOP_STRIDE: begin
                    dec_o.vtype_sel     = 1'b0;
                    dec_o.lumop_sel     = 1'b0;
                    dec_o.data_mux2_sel = 1'b1;
                end
                default: begin
                    dec_o.data_mux2_sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vec_seq_controller.sv
// -----------------------------------------------------------------------------
// vec_seq_controller
// Accepts vector instructions from the scalar core and sequences them in
// beats of LANES elements.
//   clk, reset      : clock, asynchronous active-low reset
//   vec_inst        : instruction word, qualified by inst_valid
//   inst_ready      : high only in IDLE (and not in reset)
//   csr_vl          : current vl, sampled once at acceptance
//   lsu_ack         : LSU finished the outstanding load beat (MEM_WAIT only)
//   csrwr_en        : one-cycle CSR write for vset* instructions
//   vl_sel .. ld_inst : decode outputs, held from acceptance until the next
//                       acceptance
//   vec_reg_wr_en   : per-beat register-file write strobe
//   lsu_req         : one-cycle LSU beat request
//   beat_idx        : beat currently being processed
//   busy, inst_done : in-flight flag and one-cycle completion pulse
// -----------------------------------------------------------------------------
module vec_seq_controller
    import vector_processor_defs::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned LANES  = 4,
    parameter  int unsigned MAX_VL = 64,
    localparam int unsigned VL_W   = $clog2(MAX_VL) + 1,
    localparam int unsigned BEAT_W = $clog2(MAX_VL / LANES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   vec_inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [VL_W-1:0]   csr_vl,
    input  logic              lsu_ack,
    output logic              csrwr_en,
    output logic              vl_sel,
    output logic              vtype_sel,
    output logic              rs1_sel,
    output logic              rs1rd_de,
    output logic              lumop_sel,
    output logic              vec_reg_wr_en,
    output logic              mask_operation,
    output logic              mask_wr_en,
    output logic [1:0]        data_mux1_sel,
    output logic              data_mux2_sel,
    output logic              stride_sel,
    output logic              ld_inst,
    output logic              lsu_req,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              busy,
    output logic              inst_done
);

    localparam int unsigned RND_W = VL_W + 1;

    vseq_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    vdec_t             dec_q, dec_d;
    logic              is_load_q, is_load_d;

    vdec_t             dec_new;
    logic              new_conf;
    logic              new_vec;
    logic              new_load;

    logic              accept;
    logic              last_beat;
    logic [VL_W-1:0]   vl_clamped;
    logic [RND_W-1:0]  vl_round;
    logic [BEAT_W-1:0] beats_new;

    vec_inst_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst_i    (vec_inst),
        .dec_o     (dec_new),
        .is_conf_o (new_conf),
        .is_vec_o  (new_vec),
        .is_load_o (new_load)
    );

    // vl above MAX_VL is illegal; clamping keeps the beat count inside BEAT_W.
    always_comb begin
        vl_clamped = (csr_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : csr_vl;
        vl_round   = {1'b0, vl_clamped} + RND_W'(LANES - 1);
        beats_new  = BEAT_W'(vl_round / RND_W'(LANES));
    end

    assign inst_ready = (state_q == IDLE) && reset;
    assign accept     = inst_valid && inst_ready;
    assign busy       = (state_q != IDLE);
    assign last_beat  = (beat_idx_q == beats_q - BEAT_W'(1));

    always_comb begin
        state_d       = state_q;
        beat_idx_d    = beat_idx_q;
        beats_d       = beats_q;
        dec_d         = dec_q;
        is_load_d     = is_load_q;
        csrwr_en      = 1'b0;
        vec_reg_wr_en = 1'b0;
        lsu_req       = 1'b0;
        inst_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dec_d      = dec_new;
                    is_load_d  = new_load;
                    beats_d    = beats_new;
                    beat_idx_d = '0;
                    if (new_conf) begin
                        state_d = CONFIG;
                    end else if (new_vec && (csr_vl != '0)) begin
                        state_d = EXEC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CONFIG: begin
                csrwr_en = 1'b1;
                state_d  = DONE;
            end
            EXEC: begin
                if (is_load_q) begin
                    lsu_req = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    vec_reg_wr_en = 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_idx_d = beat_idx_q + BEAT_W'(1);
                    end
                end
            end
            MEM_WAIT: begin
                // lsu_ack is combinational here so an ack arriving in the
                // same cycle MEM_WAIT is entered is taken immediately.
                if (lsu_ack) begin
                    vec_reg_wr_en = 1'b1;
                    beat_idx_d    = beat_idx_q + BEAT_W'(1);
                    state_d       = last_beat ? DONE : EXEC;
                end
            end
            DONE: begin
                inst_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            beats_q    <= '0;
            dec_q      <= '0;
            is_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            beats_q    <= beats_d;
            dec_q      <= dec_d;
            is_load_q  <= is_load_d;
        end
    end

    assign beat_idx       = beat_idx_q;
    assign vl_sel         = dec_q.vl_sel;
    assign vtype_sel      = dec_q.vtype_sel;
    assign rs1_sel        = dec_q.rs1_sel;
    assign rs1rd_de       = dec_q.rs1rd_de;
    assign lumop_sel      = dec_q.lumop_sel;
    assign mask_operation = dec_q.mask_operation;
    assign mask_wr_en     = dec_q.mask_wr_en;
    assign data_mux1_sel  = dec_q.data_mux1_sel;
    assign data_mux2_sel  = dec_q.data_mux2_sel;
    assign stride_sel     = dec_q.stride_sel;
    assign ld_inst        = dec_q.ld_inst;

endmodule
